dram_frame_reader: RTL and testbench

DRAM_FRAME_READER -- requirements
Module: dram_frame_reader

---
 rtl/dram_frame_reader_if.sv | 30 +++
 rtl/dram_frame_reader.sv | 218 +++++++++++++++++++++
 tb/tb_dram_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_frame_reader_if.sv
// Request/response bus to the DRAM controller plus the downstream word stream.
// The reader side drives requests and stream data; the other side answers.
interface dram_frame_reader_if #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int DRAM_DATA_WIDTH = 512
);
  logic [AXI_ADDR_WIDTH-1:0]  dram_read_addr;
  logic [7:0]                 dram_read_len;
  logic                       dram_read_en;
  logic                       dram_read_busy;
  logic [DRAM_DATA_WIDTH-1:0] dram_read_data;
  logic                       dram_read_data_valid;
  logic [DRAM_DATA_WIDTH-1:0] pix_data;
  logic                       pix_valid;
  logic                       pix_ready;

  modport master (
    output dram_read_addr, dram_read_len, dram_read_en,
    input  dram_read_busy, dram_read_data, dram_read_data_valid,
    output pix_data, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  dram_read_addr, dram_read_len, dram_read_en,
    output dram_read_busy, dram_read_data, dram_read_data_valid,
    input  pix_data, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/dram_frame_reader.sv
// Fetches a frame of DRAM words one read at a time into a first-word
// fall-through buffer that feeds a ready/valid stream.
module dram_frame_reader #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0] frame_base_addr,
  input  logic [23:0]               frame_words,
  input  logic                      frame_start,
  input  logic                      frame_loop,
  input  logic                      frame_stop,
  dram_frame_reader_if.master       rd_if,
  output logic                      frame_done,
  output logic                      reader_busy,
  output logic [7:0]                read_err_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BYTES = DRAM_DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [AXI_ADDR_WIDTH-1:0] WORD_BYTES = AXI_ADDR_WIDTH'(BYTES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  state_t                      state_r;
  logic [AXI_ADDR_WIDTH-1:0]   base_r;
  logic [23:0]                 words_r;
  logic [23:0]                 index_r;
  logic                        stop_r;
  logic                        en_r;
  logic [AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [7:0]                  len_r;
  logic                        done_r;
  logic                        busy_r;
  logic [7:0]                  err_cnt_r;

  logic [DRAM_DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [CNT_W-1:0]            count_r;
  logic [DRAM_DATA_WIDTH-1:0]  head_r;
  logic                        valid_r;

  logic                        push_s;
  logic                        pop_s;
  logic                        last_s;
  logic                        stop_s;
  logic [DRAM_DATA_WIDTH-1:0]  push_data_s;
  logic [AXI_ADDR_WIDTH-1:0]   req_addr_s;
  logic [PTR_W-1:0]            rd_nx_s;
  logic [CNT_W-1:0]            cnt_nx_s;

  // Push/pop decode, next buffer occupancy and the next request address
  always_comb begin
    push_s      = 1'b0;
    push_data_s = '0;
    if ((state_r == WAIT_DATA) && !rd_if.dram_read_busy) begin
      push_s = 1'b1;
      if (rd_if.dram_read_data_valid) begin
        push_data_s = rd_if.dram_read_data;
      end else begin
        push_data_s = '0;
      end
    end else begin
      push_s = 1'b0;
    end
    pop_s = valid_r & rd_if.pix_ready;
    if (pop_s) begin
      rd_nx_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_nx_s = rd_ptr_r;
    end
    cnt_nx_s   = count_r + (push_s ? CNT_ONE : '0) - (pop_s ? CNT_ONE : '0);
    last_s     = (index_r == (words_r - 24'd1));
    stop_s     = stop_r | frame_stop;
    req_addr_s = base_r + (AXI_ADDR_WIDTH'(index_r) * WORD_BYTES);
  end

  // Frame sequencer with registered bus and status outputs
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_r   <= IDLE;
      base_r    <= '0;
      words_r   <= 24'd0;
      index_r   <= 24'd0;
      stop_r    <= 1'b0;
      en_r      <= 1'b0;
      addr_r    <= '0;
      len_r     <= 8'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      en_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          stop_r <= 1'b0;
          if (frame_start && (frame_words != 24'd0)) begin
            base_r  <= frame_base_addr;
            words_r <= frame_words;
            index_r <= 24'd0;
            busy_r  <= 1'b1;
            state_r <= REQ;
          end else begin
            busy_r <= 1'b0;
          end
        end
        REQ: begin
          if (en_r) begin
            // The request is already on the bus, so a stop now must wait for its data
            stop_r  <= frame_stop;
            state_r <= WAIT_BUSY;
          end else if (frame_stop) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if ((count_r < DEPTH_CNT) && !rd_if.dram_read_busy) begin
            en_r   <= 1'b1;
            addr_r <= req_addr_s;
            len_r  <= 8'd0;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT_BUSY: begin
          stop_r <= stop_s;
          if (rd_if.dram_read_busy) begin
            state_r <= WAIT_DATA;
          end else begin
            state_r <= WAIT_BUSY;
          end
        end
        WAIT_DATA: begin
          if (push_s) begin
            stop_r <= 1'b0;
            if (!rd_if.dram_read_data_valid && (err_cnt_r != 8'd255)) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
            if (stop_s) begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else if (last_s) begin
              done_r  <= 1'b1;
              index_r <= 24'd0;
              if (frame_loop) begin
                state_r <= REQ;
              end else begin
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            end else begin
              index_r <= index_r + 24'd1;
              state_r <= REQ;
            end
          end else begin
            stop_r <= stop_s;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Buffer storage; contents need no reset because occupancy guards every read
  always_ff @(posedge m_axi_aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Buffer pointers, occupancy and the registered head word
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_nx_s;
      count_r  <= cnt_nx_s;
      valid_r  <= (cnt_nx_s != '0);
      // A word written into an otherwise empty buffer bypasses storage to the head
      if (cnt_nx_s == '0) begin
        head_r <= '0;
      end else if (push_s && (cnt_nx_s == CNT_ONE)) begin
        head_r <= push_data_s;
      end else begin
        head_r <= mem_r[rd_nx_s];
      end
    end
  end

  assign rd_if.dram_read_en   = en_r;
  assign rd_if.dram_read_addr = addr_r;
  assign rd_if.dram_read_len  = len_r;
  assign rd_if.pix_valid      = valid_r;
  assign rd_if.pix_data       = head_r;
  assign frame_done           = done_r;
  assign reader_busy          = busy_r;
  assign read_err_cnt         = err_cnt_r;
endmodule

// File: tb/tb_dram_frame_reader.sv
// Randomized bench for dram_frame_reader: a DRAM responder plus a frame-level
// model (expected word queue, address walk, done/error bookkeeping).
module tb_dram_frame_reader;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] frame_base_addr = '0;
  logic [23:0]   frame_words = 24'd0;
  logic          frame_start = 1'b0;
  logic          frame_loop = 1'b0;
  logic          frame_stop = 1'b0;
  logic          frame_done;
  logic          reader_busy;
  logic [7:0]    read_err_cnt;

  dram_frame_reader_if #(.AXI_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) rd_if ();

  dram_frame_reader #(.AXI_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .frame_base_addr(frame_base_addr), .frame_words(frame_words),
    .frame_start(frame_start), .frame_loop(frame_loop), .frame_stop(frame_stop),
    .rd_if(rd_if),
    .frame_done(frame_done), .reader_busy(reader_busy), .read_err_cnt(read_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state, owned by the negedge monitor
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] out_log[$];
  logic [AW-1:0] m_base;
  int  m_words, m_idx, m_err, frm_rd;
  bit  m_active = 0, m_act_next = 0, m_stop = 0;
  int  resp_cnt = 0, stale_cnt = 0;
  bit  pending = 0, pend_v, resp_v;
  logic [DW-1:0] pend_d, resp_d;
  int  done_cnt = 0, rd_cnt = 0, pop_cnt = 0;
  // knobs, owned by the main sequence
  int  ready_mode = 1, lat_fixed = 3, err_mode = 0, force_err_idx = -1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Responder and model, sampled on the falling edge
  initial begin
    bit            exp_done;
    logic [AW-1:0] ea;
    rd_if.dram_read_busy = 1'b0;
    rd_if.dram_read_data_valid = 1'b0;
    rd_if.dram_read_data = '0;
    rd_if.pix_ready = 1'b0;
    m_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_active = 0; m_act_next = 0; m_stop = 0; m_err = 0;
        resp_cnt = 0; pending = 0; stale_cnt = 3;
        rd_if.dram_read_busy = 1'b0;
        rd_if.dram_read_data_valid = 1'b1;
        rd_if.dram_read_data = {16{32'hDEAD_BEEF}};
      end else begin
        exp_done = 0;
        if (pending) begin
          pending = 0;
          exp_q.push_back(pend_v ? pend_d : '0);
          if (!pend_v && m_err < 255) m_err++;
          if (m_stop) begin
            m_active = 0; m_stop = 0;
          end else if (m_idx == m_words - 1) begin
            exp_done = 1; done_cnt++; m_idx = 0;
            if (!frame_loop) m_active = 0;
          end else begin
            m_idx++;
          end
        end
        if (m_act_next) begin
          m_active = 1; m_act_next = 0; m_idx = 0; m_stop = 0; frm_rd = 0;
        end
        if (stale_cnt > 0) stale_cnt--;
        else rd_if.dram_read_data_valid = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            rd_if.dram_read_busy = 1'b0;
            rd_if.dram_read_data_valid = resp_v;
            rd_if.dram_read_data = resp_d;
            pending = 1; pend_v = resp_v; pend_d = resp_d;
          end
        end else if (rd_if.dram_read_en) begin
          chk("unexpected_read", {31'd0, !m_active}, '0);
          ea = m_base + 32'(m_idx * 64);
          chk("read_addr", rd_if.dram_read_addr, ea);
          chk("read_len", rd_if.dram_read_len, '0);
          addr_log.push_back(rd_if.dram_read_addr);
          rd_cnt++;
          resp_cnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(2, 5);
          for (int i = 0; i < DW / 32; i++) resp_d[i*32 +: 32] = $urandom();
          if (frm_rd == force_err_idx || err_mode == 2) resp_v = 0;
          else if (err_mode == 1) resp_v = ($urandom_range(0, 7) != 0);
          else resp_v = 1;
          frm_rd++;
          rd_if.dram_read_busy = 1'b1;
        end
        if (rd_if.dram_read_en && resp_cnt != 0 && rd_if.dram_read_busy == 1'b0) begin
          chk("second_outstanding", 1'b1, 1'b0);
        end
        if (frame_stop && m_active) m_stop = 1;
        if (frame_start && !m_active && !m_act_next && frame_words != 24'd0) begin
          m_act_next = 1; m_base = frame_base_addr; m_words = int'(frame_words);
        end
        if (ready_mode == 0) rd_if.pix_ready = 1'b0;
        else if (ready_mode == 1) rd_if.pix_ready = 1'b1;
        else rd_if.pix_ready = ($urandom_range(0, 3) != 0);
        chk("pix_valid", rd_if.pix_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("pix_data", rd_if.pix_data, exp_q[0]);
          if (rd_if.pix_ready) begin
            out_log.push_back(rd_if.pix_data);
            void'(exp_q.pop_front());
            pop_cnt++;
          end
        end
        chk("frame_done", frame_done, exp_done);
        chk("reader_busy", reader_busy, m_active);
        chk("read_err_cnt", read_err_cnt, m_err);
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] base, input int words, input logic loop);
    @(posedge clk); #1;
    addr_log.delete();
    frame_base_addr = base; frame_words = 24'(words); frame_loop = loop; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while ((m_active || m_act_next || pending || resp_cnt != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, {31'd0, n >= budget}, '0);
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!rd_if.dram_read_busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, {31'd0, n >= 200}, '0);
  endtask

  task automatic pulse_stop();
    frame_stop = 1'b1;
    @(posedge clk); #1;
    frame_stop = 1'b0;
  endtask

  initial begin
    int d0, r0, p0, o0, n;
    #1;
    chk("rst_en", rd_if.dram_read_en, '0);
    chk("rst_addr", rd_if.dram_read_addr, '0);
    chk("rst_pix_valid", rd_if.pix_valid, '0);
    chk("rst_pix_data", rd_if.pix_data, '0);
    chk("rst_busy", reader_busy, '0);
    chk("rst_err", read_err_cnt, '0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // basic frame with a fixed 3-cycle responder
    d0 = done_cnt; o0 = out_log.size();
    start_frame(32'h1000_0000, 4, 1'b0);
    wait_idle("t1_idle", 300);
    chk("t1_addr0", addr_log[0], 32'h1000_0000);
    chk("t1_addr1", addr_log[1], 32'h1000_0040);
    chk("t1_addr2", addr_log[2], 32'h1000_0080);
    chk("t1_addr3", addr_log[3], 32'h1000_00C0);
    chk("t1_words_out", out_log.size() - o0, 4);
    chk("t1_done", done_cnt - d0, 1);

    // second read of the frame comes back invalid
    force_err_idx = 1; d0 = done_cnt; o0 = out_log.size();
    start_frame(32'h0000_4000, 4, 1'b0);
    wait_idle("t2_idle", 300);
    force_err_idx = -1;
    chk("t2_zero_word", out_log[o0 + 1], '0);
    chk("t2_err_cnt", read_err_cnt, 1);
    chk("t2_done", done_cnt - d0, 1);

    // backpressure: reads stop once the buffer is full
    lat_fixed = 0; ready_mode = 0; r0 = rd_cnt; p0 = pop_cnt; d0 = done_cnt;
    start_frame(32'h2000_0000, 40, 1'b0);
    repeat (400) @(posedge clk);
    #1;
    chk("t3_reads_stalled", rd_cnt - r0, DEPTH);
    chk("t3_busy", reader_busy, 1);
    ready_mode = 2;
    wait_idle("t3_idle", 3000);
    chk("t3_reads", rd_cnt - r0, 40);
    chk("t3_pops", pop_cnt - p0, 40);
    chk("t3_done", done_cnt - d0, 1);

    // looping two-word frame, then stop with a read in flight
    d0 = done_cnt; r0 = rd_cnt; p0 = pop_cnt;
    start_frame(32'h3000_0100, 2, 1'b1);
    n = 0;
    while (done_cnt < d0 + 3 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("t4_loop_timeout", {31'd0, n >= 3000}, '0);
    wait_busy("t4_busy_timeout");
    d0 = done_cnt;
    pulse_stop();
    wait_idle("t4_idle", 300);
    chk("t4_addr0", addr_log[0], 32'h3000_0100);
    chk("t4_addr1", addr_log[1], 32'h3000_0140);
    chk("t4_addr2", addr_log[2], 32'h3000_0100);
    chk("t4_addr3", addr_log[3], 32'h3000_0140);
    chk("t4_no_done_after_stop", done_cnt, d0);
    chk("t4_all_delivered", pop_cnt - p0, rd_cnt - r0);

    // address wraps modulo 2^32
    start_frame(32'hFFFF_FFC0, 2, 1'b0);
    wait_idle("t5_idle", 300);
    chk("t5_addr0", addr_log[0], 32'hFFFF_FFC0);
    chk("t5_addr1", addr_log[1], 32'h0000_0000);

    // asynchronous reset with a read in flight
    start_frame(32'h4000_0000, 8, 1'b0);
    wait_busy("t6_busy_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_en", rd_if.dram_read_en, '0);
    chk("t6_addr", rd_if.dram_read_addr, '0);
    chk("t6_len", rd_if.dram_read_len, '0);
    chk("t6_pix_valid", rd_if.pix_valid, '0);
    chk("t6_pix_data", rd_if.pix_data, '0);
    chk("t6_done", frame_done, '0);
    chk("t6_busy", reader_busy, '0);
    chk("t6_err", read_err_cnt, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    start_frame(32'h5000_0000, 3, 1'b0);
    wait_idle("t6_idle", 300);
    chk("t6_restart_addr", addr_log[0], 32'h5000_0000);
    chk("t6_restart_reads", addr_log.size(), 3);

    // zero-length start is ignored
    r0 = rd_cnt;
    start_frame(32'h6000_0000, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t7_zero_busy", reader_busy, '0);
    chk("t7_zero_reads", rd_cnt - r0, 0);

    // random frames, random errors, backpressure and ignored restarts
    err_mode = 1;
    for (int k = 0; k < 6; k++) begin
      d0 = done_cnt;
      start_frame($urandom(), $urandom_range(1, 24), 1'b0);
      repeat (4) @(posedge clk);
      #1;
      frame_base_addr = $urandom();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      wait_idle("rand_idle", 3000);
      chk("rand_done", done_cnt - d0, 1);
    end

    // error counter saturates
    err_mode = 2; ready_mode = 1; lat_fixed = 2;
    start_frame(32'h7000_0000, 260, 1'b0);
    wait_idle("t8_idle", 6000);
    chk("t8_err_sat", read_err_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
